// File: rtl/apu_arb_pkg.sv
// apu_arb_pkg: shared types and helpers for the APU arbiter.
// Arbiter FSM states, outstanding-counter width and tag width helper.
package apu_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Outstanding counters must hold MAX_OUTST up to 15.
  localparam int CNT_W = 4;

  // Tag width: enough bits to name every requester, never less than one.
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apu_rr_picker.sv
// apu_rr_picker: combinational round-robin search.
// Returns the first eligible index at or above rr_ptr, wrapping modulo NB_REQ.
module apu_rr_picker #(
  parameter int NB_REQ = 2,
  parameter int TAG_W  = 1
)(
  input  logic [NB_REQ-1:0] eligible,
  input  logic [TAG_W-1:0]  rr_ptr,
  output logic [TAG_W-1:0]  winner,
  output logic              any
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NB_REQ) idx = idx - NB_REQ;
      if (eligible[idx]) begin
        winner = TAG_W'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apu_arbiter.sv
// apu_arbiter: round-robin sharing of one FPU between NB_REQ requesters.
// Requests are tagged with the requester index; responses are routed back by tag.
// Optional macro APU_ARB_STATS_EN adds per-requester saturating grant counters.
module apu_arbiter
  import apu_arb_pkg::*;
#(
  parameter int NB_REQ     = 2,
  parameter int WIDTH      = 32,
  parameter int OP_WIDTH   = 6,
  parameter int FLAG_WIDTH = 5,
  parameter int MAX_OUTST  = 4,
  localparam int TAG_W     = tag_w(NB_REQ)
)(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NB_REQ-1:0]          req_i,
  output logic [NB_REQ-1:0]          gnt_o,
  input  logic [NB_REQ*3*WIDTH-1:0]  operands_i,
  input  logic [NB_REQ*OP_WIDTH-1:0] op_i,
  output logic [NB_REQ-1:0]          rvalid_o,
  output logic [WIDTH-1:0]           result_o,
  output logic [FLAG_WIDTH-1:0]      rflags_o,
  output logic                       apu_req_o,
  input  logic                       apu_gnt_i,
  output logic [3*WIDTH-1:0]         apu_operands_o,
  output logic [OP_WIDTH-1:0]        apu_op_o,
  output logic [TAG_W-1:0]           apu_tag_o,
  input  logic                       apu_rvalid_i,
  input  logic [TAG_W-1:0]           apu_rtag_i,
  input  logic [WIDTH-1:0]           apu_result_i,
  input  logic [FLAG_WIDTH-1:0]      apu_rflags_i,
  output logic                       protocol_err_o
`ifdef APU_ARB_STATS_EN
  ,
  output logic [NB_REQ*16-1:0]       grant_cnt_o
`endif
);

  arb_state_e        state_reg, state_next;
  logic [TAG_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [TAG_W-1:0]  winner_q_reg, winner_q_next;
  logic              err_reg;

  logic [NB_REQ-1:0] eligible;
  logic [NB_REQ-1:0] gnt;
  logic [NB_REQ-1:0] rvalid;
  logic [NB_REQ-1:0] orphan;
  logic [TAG_W-1:0]  winner;
  logic [TAG_W-1:0]  sel;
  logic              any;
  logic              req_out;
  logic              drop_err;
  logic              resp_ok;
  logic              err_set;

  // Pointer to the index after w, wrapping at NB_REQ.
  function automatic logic [TAG_W-1:0] ptr_after(input logic [TAG_W-1:0] w);
    if (int'(w) >= NB_REQ - 1) return '0;
    return w + TAG_W'(1);
  endfunction

  apu_rr_picker #(
    .NB_REQ (NB_REQ),
    .TAG_W  (TAG_W)
  ) u_picker (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_reg),
    .winner   (winner),
    .any      (any)
  );

  // Responses carrying an out-of-range tag are dropped entirely.
  assign resp_ok = apu_rvalid_i && (int'(apu_rtag_i) < NB_REQ);

  // Per-requester outstanding counters, eligibility and response decode.
  for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_req
    logic [CNT_W-1:0] cnt_reg;
    logic             dec;

    assign rvalid[gi]   = resp_ok && (int'(apu_rtag_i) == gi);
    assign dec          = rvalid[gi] && (cnt_reg != '0);
    assign orphan[gi]   = rvalid[gi] && (cnt_reg == '0);
    assign eligible[gi] = req_i[gi] && (cnt_reg < CNT_W'(MAX_OUTST));

    // Count in-flight operations; simultaneous grant and response cancel out.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_reg <= '0;
      end else if (gnt[gi] && !dec) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end else if (!gnt[gi] && dec) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

  // Arbitration FSM: pick in IDLE, lock the winner in HOLD until accepted.
  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    winner_q_next = winner_q_reg;
    gnt           = '0;
    sel           = winner;
    req_out       = 1'b0;
    drop_err      = 1'b0;
    case (state_reg)
      IDLE: begin
        sel     = winner;
        req_out = any;
        if (any) begin
          if (apu_gnt_i) begin
            gnt[winner] = 1'b1;
            rr_ptr_next = ptr_after(winner);
          end else begin
            winner_q_next = winner;
            state_next    = HOLD;
          end
        end
      end
      HOLD: begin
        sel     = winner_q_reg;
        req_out = 1'b1;
        if (!req_i[winner_q_reg]) begin
          drop_err   = 1'b1;
          state_next = IDLE;
        end else if (apu_gnt_i) begin
          gnt[winner_q_reg] = 1'b1;
          rr_ptr_next       = ptr_after(winner_q_reg);
          state_next        = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign err_set = drop_err || (apu_rvalid_i && !resp_ok) || (|orphan);

  // State, round-robin pointer, held winner and sticky error register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      winner_q_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      winner_q_reg <= winner_q_next;
      err_reg      <= err_reg | err_set;
    end
  end

  // Every output is forced to zero while reset is asserted.
  assign gnt_o          = rst_i ? '0 : gnt;
  assign apu_req_o      = rst_i ? 1'b0 : req_out;
  assign apu_tag_o      = rst_i ? '0 : sel;
  assign apu_operands_o = rst_i ? '0 : operands_i[int'(sel)*3*WIDTH +: 3*WIDTH];
  assign apu_op_o       = rst_i ? '0 : op_i[int'(sel)*OP_WIDTH +: OP_WIDTH];
  assign rvalid_o       = rst_i ? '0 : rvalid;
  assign result_o       = rst_i ? '0 : apu_result_i;
  assign rflags_o       = rst_i ? '0 : apu_rflags_i;
  assign protocol_err_o = rst_i ? 1'b0 : err_reg;

`ifdef APU_ARB_STATS_EN
  for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_stats
    logic [15:0] stat_reg;

    // Saturating grant counter for requester gi.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stat_reg <= '0;
      end else if (gnt[gi] && (stat_reg != 16'hFFFF)) begin
        stat_reg <= stat_reg + 16'd1;
      end
    end

    assign grant_cnt_o[gi*16 +: 16] = rst_i ? 16'd0 : stat_reg;
  end
`endif

endmodule
